// File: rtl/ddr2_host_pkg.sv
// Shared types for the DDR2 host command front end: host command encoding,
// the queued command record and the block-size decode helper.
package ddr2_host_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        CMD_NOP = 3'b000,
        CMD_SCR = 3'b001,
        CMD_SCW = 3'b010,
        CMD_BLR = 3'b011,
        CMD_BLW = 3'b100
    } host_cmd_e;

    // One command FIFO entry, exactly as the host presented it.
    typedef struct packed {
        logic [2:0]        cmd;
        logic [1:0]        sz;
        logic [2:0]        op;
        logic [ADDR_W-1:0] addr;
    } host_cmd_t;

    // Block size code to beat count: 8, 16, 24 or 32 beats.
    function automatic logic [5:0] sz_to_beats(input logic [1:0] sz);
        return ({4'b0000, sz} + 6'd1) << 3;
    endfunction

endpackage

// File: rtl/ingress_sync_fifo.sv
// Single-clock FIFO with occupancy count and valid/ready pop side.
// DEPTH must be a power of two so the pointers wrap by overflowing.
module ingress_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       valid,
    input  logic                       ready,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Pop needs a valid head; push is refused only when full and not popping.
    always_comb begin
        do_pop   = ready && (count_q != '0);
        do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and occupancy registers; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign valid = (count_q != '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/host_cmd_ingress.sv
// Host command ingress: decodes host commands into a command FIFO and a
// write-data FIFO, collecting block-write beats before releasing the BLW.
// Optional: HOST_CMD_ALIGN_CHECK_EN rejects block commands whose address is
// not 8-word aligned (block-write beats are then swallowed).
// Handshake: a FIFO head is consumed on any cycle where valid && ready;
// valid never depends on ready. The host may issue a command only in a
// cycle following one in which notfull was high.
module host_cmd_ingress
    import ddr2_host_pkg::*;
#(
    parameter int CMD_DEPTH  = 64,
    parameter int DATA_DEPTH = 128,
    parameter int MAX_BURST  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        cmd,
    input  logic [1:0]        sz,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [6:0]        fillcount,
    output logic              notfull,
    output logic              q_valid,
    input  logic              q_ready,
    output logic [2:0]        q_cmd,
    output logic [1:0]        q_sz,
    output logic [2:0]        q_op,
    output logic [ADDR_W-1:0] q_addr,
    output logic              wd_valid,
    input  logic              wd_ready,
    output logic [DATA_W-1:0] wd_data,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic              dbg_state
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WDATA = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [4:0]  beat_cnt_q, beat_cnt_d;
    host_cmd_t   pend_q, pend_d;
    logic        discard_q, discard_d;
    logic        notfull_q, notfull_d;
    logic        err_illegal_q, err_illegal_d;
    logic        err_overflow_q, err_overflow_d;

    logic        cmd_push, data_push, misalign;
    host_cmd_t   cmd_push_data, cmd_head;
    logic [CAW:0] cmd_count, cmd_count_next;
    logic [DAW:0] data_count, data_count_next;

    // Command decode and block-write beat collection.
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        pend_d         = pend_q;
        discard_d      = discard_q;
        err_illegal_d  = 1'b0;
        err_overflow_d = 1'b0;
        cmd_push       = 1'b0;
        data_push      = 1'b0;
        cmd_push_data  = '{cmd: cmd, sz: sz, op: op, addr: addr};
`ifdef HOST_CMD_ALIGN_CHECK_EN
        misalign = (addr[2:0] != 3'b000);
`else
        misalign = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd != CMD_NOP) begin
                    if (!notfull_q) begin
                        err_overflow_d = 1'b1;
                    end else begin
                        case (cmd)
                            CMD_SCR: cmd_push = 1'b1;
                            CMD_SCW: begin
                                cmd_push  = 1'b1;
                                data_push = 1'b1;
                            end
                            CMD_BLR: begin
                                cmd_push      = !misalign;
                                err_illegal_d = misalign;
                            end
                            CMD_BLW: begin
                                // Beat 0 rides on the command cycle.
                                data_push     = !misalign;
                                err_illegal_d = misalign;
                                discard_d     = misalign;
                                pend_d        = cmd_push_data;
                                beat_cnt_d    = 5'(sz_to_beats(sz) - 6'd1);
                                state_d       = ST_WDATA;
                            end
                            default: err_illegal_d = 1'b1;
                        endcase
                    end
                end
            end
            ST_WDATA: begin
                data_push  = !discard_q;
                beat_cnt_d = beat_cnt_q - 5'd1;
                if (beat_cnt_q == 5'd1) begin
                    cmd_push      = !discard_q;
                    cmd_push_data = pend_q;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flow control looks at occupancy after this cycle's push and pop, so a
    // full-length burst always fits once notfull is seen high.
    always_comb begin
        cmd_count_next  = cmd_count + (CAW+1)'(cmd_push) - (CAW+1)'(q_valid && q_ready);
        data_count_next = data_count + (DAW+1)'(data_push) - (DAW+1)'(wd_valid && wd_ready);
        notfull_d = (state_q == ST_IDLE) && (state_d == ST_IDLE) &&
                    (cmd_count_next <= (CAW+1)'(CMD_DEPTH - 2)) &&
                    (data_count_next <= (DAW+1)'(DATA_DEPTH - MAX_BURST));
    end

    // Control registers; a reset mid-burst drops the pending block write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            beat_cnt_q     <= '0;
            pend_q         <= '0;
            discard_q      <= 1'b0;
            notfull_q      <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            pend_q         <= pend_d;
            discard_q      <= discard_d;
            notfull_q      <= notfull_d;
            err_illegal_q  <= err_illegal_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    ingress_sync_fifo #(.WIDTH($bits(host_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_push),
        .push_data (cmd_push_data),
        .valid     (q_valid),
        .ready     (q_ready),
        .head      (cmd_head),
        .count     (cmd_count)
    );

    ingress_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_push),
        .push_data (din),
        .valid     (wd_valid),
        .ready     (wd_ready),
        .head      (wd_data),
        .count     (data_count)
    );

    assign fillcount    = 7'(cmd_count);
    assign notfull      = notfull_q;
    assign q_cmd        = cmd_head.cmd;
    assign q_sz         = cmd_head.sz;
    assign q_op         = cmd_head.op;
    assign q_addr       = cmd_head.addr;
    assign err_illegal  = err_illegal_q;
    assign err_overflow = err_overflow_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_host_cmd_ingress.sv
// Bench for host_cmd_ingress: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference of the host protocol.
module tb_host_cmd_ingress;
    import ddr2_host_pkg::*;

    localparam int CMD_DEPTH  = 64;
    localparam int DATA_DEPTH = 128;
    localparam int MAX_BURST  = 32;
`ifdef HOST_CMD_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic              clk, reset;
    logic [2:0]        cmd, op;
    logic [1:0]        sz;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [6:0]        fillcount;
    logic              notfull, q_valid, q_ready, wd_valid, wd_ready;
    logic [2:0]        q_cmd, q_op;
    logic [1:0]        q_sz;
    logic [ADDR_W-1:0] q_addr;
    logic [DATA_W-1:0] wd_data;
    logic              err_illegal, err_overflow, dbg_state;

    host_cmd_ingress #(.CMD_DEPTH(CMD_DEPTH), .DATA_DEPTH(DATA_DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .sz(sz), .op(op), .addr(addr), .din(din),
        .fillcount(fillcount), .notfull(notfull), .q_valid(q_valid), .q_ready(q_ready),
        .q_cmd(q_cmd), .q_sz(q_sz), .q_op(q_op), .q_addr(q_addr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .err_illegal(err_illegal), .err_overflow(err_overflow), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected queue contents and host-visible flags.
    logic [32:0]       exp_q[$];
    logic [DATA_W-1:0] exp_wd_q[$];
    bit                m_burst, m_discard, m_notfull, m_ill, m_ovf;
    int                m_left;
    logic [32:0]       m_pend;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the protocol rules for one clock edge to the reference state.
    task automatic model_step();
        bit          was_burst, pop_c, pop_d, push_c, push_d, bad_align;
        logic [32:0] cval;
        if (reset) begin
            exp_q.delete();
            exp_wd_q.delete();
            m_burst = 0; m_notfull = 0; m_ill = 0; m_ovf = 0;
            return;
        end
        was_burst = m_burst;
        pop_c  = q_ready && (exp_q.size() > 0);
        pop_d  = wd_ready && (exp_wd_q.size() > 0);
        push_c = 0; push_d = 0;
        cval   = {cmd, sz, op, addr};
        m_ill  = 0; m_ovf = 0;
        bad_align = ALIGN_EN && (addr[2:0] != 3'b000);
        if (m_burst) begin
            push_d = !m_discard;
            m_left--;
            if (m_left == 0) begin
                push_c  = !m_discard;
                cval    = m_pend;
                m_burst = 0;
            end
        end else if (cmd != 3'd0) begin
            if (!m_notfull) m_ovf = 1;
            else if (cmd > 3'd4) m_ill = 1;
            else if (cmd == 3'd1) push_c = 1;
            else if (cmd == 3'd2) begin push_c = 1; push_d = 1; end
            else if (cmd == 3'd3) begin
                if (bad_align) m_ill = 1; else push_c = 1;
            end else begin
                m_burst   = 1;
                m_left    = 8 * (int'(sz) + 1) - 1;
                m_discard = bad_align;
                m_pend    = cval;
                if (bad_align) m_ill = 1; else push_d = 1;
            end
        end
        if (pop_c) void'(exp_q.pop_front());
        if (pop_d) void'(exp_wd_q.pop_front());
        if (push_c) exp_q.push_back(cval);
        if (push_d) exp_wd_q.push_back(din);
        m_notfull = !was_burst && !m_burst && (exp_q.size() <= CMD_DEPTH - 2) &&
                    ((DATA_DEPTH - exp_wd_q.size()) >= MAX_BURST);
    endtask

    task automatic compare_all();
        check("fillcount", fillcount, exp_q.size());
        check("notfull", notfull, m_notfull);
        check("q_valid", q_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("q_head", {q_cmd, q_sz, q_op, q_addr}, exp_q[0]);
        check("wd_valid", wd_valid, exp_wd_q.size() != 0);
        if (exp_wd_q.size() != 0) check("wd_data", wd_data, exp_wd_q[0]);
        check("err_illegal", err_illegal, m_ill);
        check("err_overflow", err_overflow, m_ovf);
        check("state", dbg_state, m_burst);
    endtask

    // Driver: one clock, model update, then sample away from the edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [2:0] c, input logic [1:0] s, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        cmd = c; sz = s; op = 3'($urandom); addr = a; din = d;
    endtask

    task automatic wait_notfull();
        for (int i = 0; i < 300 && !m_notfull; i++) cyc();
        check("wait_notfull", notfull, 1'b1);
    endtask

    initial begin
        reset = 1'b1; q_ready = 1'b0; wd_ready = 1'b0;
        drive(3'd0, 2'd0, '0, '0);

        // 1: reset held, then released
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        check("t1_notfull", notfull, 1'b1);
        check("t1_fill", fillcount, 7'd0);

        // 2: SCW then SCR to the same address
        drive(3'd2, 2'd0, 25'h10, 16'hBEEF); cyc();
        drive(3'd1, 2'd0, 25'h10, 16'h0);    cyc();
        drive(3'd0, 2'd0, '0, '0);           cyc();
        check("t2_fill", fillcount, 7'd2);
        check("t2_wd", wd_data, 16'hBEEF);
        check("t2_head0", q_cmd, 3'b010);
        q_ready = 1'b1; cyc();
        check("t2_head1", q_cmd, 3'b001);
        cyc();
        q_ready = 1'b0; wd_ready = 1'b1; cyc(); wd_ready = 1'b0;

        // 3: 16-beat block write
        wait_notfull();
        drive(3'd4, 2'd1, 25'h40, 16'h1000); cyc();
        for (int i = 1; i < 16; i++) begin
            check("t3_qv_low", q_valid, 1'b0);
            cmd = 3'($urandom); din = 16'h1000 + 16'(i);
            cyc();
        end
        check("t3_qv_high", q_valid, 1'b1);
        drive(3'd0, 2'd0, '0, '0);
        q_ready = 1'b1; wd_ready = 1'b1;
        repeat (18) cyc();
        check("t3_wd_empty", wd_valid, 1'b0);
        q_ready = 1'b0; wd_ready = 1'b0;

        // 4: fill the command FIFO until flow control stops the host
        wait_notfull();
        for (int i = 0; i < 200 && m_notfull; i++) begin
            drive(3'd1, 2'd0, 25'($urandom), '0);
            cyc();
        end
        check("t4_notfull_low", notfull, 1'b0);
        check("t4_fill", fillcount, 7'd63);
        drive(3'd1, 2'd0, 25'h123, '0); cyc();
        check("t4_ovf", err_overflow, 1'b1);
        check("t4_fill_hold", fillcount, 7'd63);
        drive(3'd0, 2'd0, '0, '0);
        q_ready = 1'b1; cyc(); q_ready = 1'b0;
        check("t4_ovf_pulse", err_overflow, 1'b0);
        check("t4_notfull_back", notfull, 1'b1);
        q_ready = 1'b1; repeat (70) cyc(); q_ready = 1'b0;

        // 5: illegal command, and misaligned block read when checked
        drive(3'd7, 2'd0, '0, '0); cyc();
        check("t5_ill", err_illegal, 1'b1);
        drive(3'd0, 2'd0, '0, '0); cyc();
        check("t5_ill_pulse", err_illegal, 1'b0);
        check("t5_fill", fillcount, 7'd0);
        if (ALIGN_EN) begin
            drive(3'd3, 2'd0, 25'h3, '0); cyc();
            check("t5_align_ill", err_illegal, 1'b1);
            check("t5_align_fill", fillcount, 7'd0);
            drive(3'd0, 2'd0, '0, '0); cyc();
        end

        // 6: reset during beat 5 of a 32-beat block write
        wait_notfull();
        drive(3'd4, 2'd3, 25'h80, 16'h2000); cyc();
        for (int i = 1; i < 5; i++) begin din = 16'h2000 + 16'(i); cyc(); end
        reset = 1'b1; din = 16'h2005; cyc();
        reset = 1'b0; drive(3'd0, 2'd0, '0, '0);
        q_ready = 1'b1; wd_ready = 1'b1;
        check("t6_state", dbg_state, 1'b0);
        check("t6_wd", wd_valid, 1'b0);
        repeat (40) cyc();
        check("t6_qv", q_valid, 1'b0);

        // Random traffic, including commands issued while notfull is low
        for (int n = 0; n < 4000; n++) begin
            q_ready  = ($urandom_range(0, 3) != 0);
            wd_ready = ($urandom_range(0, 3) != 0);
            din = 16'($urandom);
            if (m_burst) begin
                cmd = 3'($urandom);
            end else if ($urandom_range(0, 9) < 4) begin
                cmd = 3'd0;
            end else begin
                cmd  = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(1, 7));
                sz   = 2'($urandom);
                op   = 3'($urandom);
                addr = 25'($urandom);
                if ($urandom_range(0, 1) == 1) addr[2:0] = 3'b000;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
